// File: rtl/input_conditioner.sv
// Four-port pin input conditioner: 2-flop synchronizer, value debouncer and
// sticky change flags per port; evt_any is the OR of the flags (CPU interrupt).
module input_conditioner_lane #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] raw,
  input  logic       clr_evt,
  output logic [7:0] stable,
  output logic       evt
);
  localparam logic [7:0] DEB = 8'(DEB_CYCLES);

  logic [7:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [7:0] stable_q, stable_d, cand_q, cand_d, cnt_q, cnt_d;
  logic       evt_q, evt_d, commit;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    commit   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d  = '0;
      cand_d = stable_q;
    end else if (sync2_q != cand_q) begin
      // a different value mid-debounce restarts the count from scratch
      cand_d = sync2_q;
      cnt_d  = 8'd1;
    end else if (cnt_q < DEB) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      stable_d = cand_q;
      cnt_d    = '0;
      commit   = 1'b1;
    end
    // a commit on the same edge as an acknowledge keeps the flag set
    evt_d = commit ? 1'b1 : (clr_evt ? 1'b0 : evt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      evt_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
    end
  end

  assign stable = stable_q;
  assign evt    = evt_q;
endmodule

module input_conditioner #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] raw1,
  input  logic [7:0] raw2,
  input  logic [7:0] raw3,
  input  logic [7:0] raw4,
  input  logic [3:0] clr_evt,
  output logic [7:0] iport1,
  output logic [7:0] iport2,
  output logic [7:0] iport3,
  output logic [7:0] iport4,
  output logic [3:0] evt,
  output logic       evt_any
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][7:0] raw, stable;

  assign raw = {raw4, raw3, raw2, raw1};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    input_conditioner_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .raw     (raw[i]),
      .clr_evt (clr_evt[i]),
      .stable  (stable[i]),
      .evt     (evt[i])
    );
  end

  assign iport1  = stable[0];
  assign iport2  = stable[1];
  assign iport3  = stable[2];
  assign iport4  = stable[3];
  assign evt_any = |evt;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (DEB_CYCLES=4): per-cycle vector table
// followed by hand-written multi-cycle sequences.
module tb_input_conditioner;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] raw1, raw2, raw3, raw4;
  logic [3:0] clr_evt;
  logic [7:0] iport1, iport2, iport3, iport4;
  logic [3:0] evt;
  logic       evt_any;

  int checks = 0;
  int errors = 0;

  input_conditioner #(.DEB_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .raw1(raw1), .raw2(raw2), .raw3(raw3), .raw4(raw4),
    .clr_evt(clr_evt),
    .iport1(iport1), .iport2(iport2), .iport3(iport3), .iport4(iport4),
    .evt(evt), .evt_any(evt_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] r1, r2, r3, r4;
    logic [3:0] clr;
    logic [7:0] e1, e2, e3, e4;
    logic [3:0] ee;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [7:0] r1, r2, r3, r4,
                     input logic [3:0] clr, input logic [7:0] e1, e2, e3, e4,
                     input logic [3:0] ee);
    vec_t v;
    v.rst = rst; v.r1 = r1; v.r2 = r2; v.r3 = r3; v.r4 = r4; v.clr = clr;
    v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e4 = e4; v.ee = ee;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic [7:0] r1, r2, r3, r4,
                       input logic [3:0] clr);
    reset = rst; raw1 = r1; raw2 = r2; raw3 = r3; raw4 = r4; clr_evt = clr;
  endtask

  initial begin
    drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);

    // reset
    add(1, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    // raw1 -> A5: unchanged through edge 6, committed on edge 7
    for (int k = 1; k <= 6; k++)
      add(0, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    add(0, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h0, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h1);
    // held flag, then acknowledge
    add(0, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h0, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h1);
    add(0, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h1, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h0);
    // clear on an already-clear bit
    add(0, 8'hA5, 8'h00, 8'h00, 8'h00, 4'hF, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h0);
    // raw2 glitch of 3 cycles is rejected
    for (int k = 1; k <= 3; k++)
      add(0, 8'hA5, 8'h3C, 8'h00, 8'h00, 4'h0, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h0);
    for (int k = 1; k <= 8; k++)
      add(0, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h0, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h0);
    // all four ports change together and commit on the same edge
    for (int k = 1; k <= 6; k++)
      add(0, 8'h01, 8'h02, 8'h04, 8'h08, 4'h0, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h0);
    add(0, 8'h01, 8'h02, 8'h04, 8'h08, 4'h0, 8'h01, 8'h02, 8'h04, 8'h08, 4'hF);
    add(0, 8'h01, 8'h02, 8'h04, 8'h08, 4'hF, 8'h01, 8'h02, 8'h04, 8'h08, 4'h0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].r1, vq[i].r2, vq[i].r3, vq[i].r4, vq[i].clr);
      step();
      check($sformatf("vec%0d", i),
            {27'd0, iport1, iport2, iport3, iport4, evt, evt_any},
            {27'd0, vq[i].e1, vq[i].e2, vq[i].e3, vq[i].e4, vq[i].ee, |vq[i].ee});
    end

    // raw3: 0x11 for 3 cycles then 0x22 -> straight to 0x22 seven edges later
    drive(0, 8'h01, 8'h02, 8'h11, 8'h08, 4'h0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("restart_pre", iport3, 8'h04);
    end
    drive(0, 8'h01, 8'h02, 8'h22, 8'h08, 4'h0);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("restart_wait", {iport3, evt}, {8'h04, 4'h0});
    end
    step();
    check("restart_commit", {iport3, evt}, {8'h22, 4'h4});

    // commit and clear on the same edge: set wins; clear next edge
    drive(0, 8'h01, 8'h02, 8'h22, 8'h08, 4'hF);
    step();
    check("pre_clear", {evt, evt_any}, {4'h0, 1'b0});
    drive(0, 8'h5A, 8'h02, 8'h22, 8'h08, 4'h0);
    for (int k = 1; k <= 6; k++) step();
    check("setwin_before", {iport1, evt}, {8'h01, 4'h0});
    drive(0, 8'h5A, 8'h02, 8'h22, 8'h08, 4'h1);
    step();
    check("setwin_commit", {iport1, evt, evt_any}, {8'h5A, 4'h1, 1'b1});
    step();
    check("setwin_clear", {evt, evt_any}, {4'h0, 1'b0});
    drive(0, 8'h5A, 8'h02, 8'h22, 8'h08, 4'h0);
    step();
    check("clear_holds", {evt, evt_any}, {4'h0, 1'b0});

    // reset mid-debounce discards the candidate; value commits after release
    drive(1, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    step();
    drive(0, 8'h00, 8'h00, 8'h00, 8'hFF, 4'h0);
    step();
    step();
    drive(1, 8'h00, 8'h00, 8'h00, 8'hFF, 4'h0);
    step();
    check("rst_mid", {iport1, iport2, iport3, iport4, evt, evt_any}, 37'd0);
    drive(0, 8'h00, 8'h00, 8'h00, 8'hFF, 4'h0);
    for (int k = 1; k <= 6; k++) step();
    check("rst_rel_6", {iport4, evt}, {8'h00, 4'h0});
    step();
    check("rst_rel_7", {iport4, evt, evt_any}, {8'hFF, 4'h8, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
